uart_tx: RTL and testbench

//  Serial byte transmitter, 8N1 (optional parity), LSB first, idle-high line.

---
 rtl/uart_tx_pkg.sv | 19 +
 rtl/uart_tx_if.sv | 22 ++
 rtl/uart_baud_gen.sv | 31 +++
 rtl/uart_tx.sv | 133 +++++++++++++
 tb/tb_uart_tx.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: frame constants, transmitter state encoding, parity helper.
package uart_tx_pkg;

   localparam int unsigned DEF_CLKS_PER_BIT = 1252;
   localparam int unsigned DATA_BITS        = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_e;

   function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-wide valid/ready source side plus serial line and status of the UART transmitter.
interface uart_tx_if;
   import uart_tx_pkg::*;

   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_valid;
   logic                 tx_ready;
   logic                 tx;
   logic                 tx_busy;
   logic                 tx_done;

   modport master (
      output tx_data, tx_valid,
      input  tx_ready, tx, tx_busy, tx_done
   );

   modport slave (
      input  tx_data, tx_valid,
      output tx_ready, tx, tx_busy, tx_done
   );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period tick generator: counts 0..CLKS_PER_BIT-1, ticks on terminal count, sync clear.
module uart_baud_gen
   import uart_tx_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   output logic o_tick,
   output logic o_pre_tick
);

   localparam int unsigned W = $clog2(CLKS_PER_BIT);

   logic [W-1:0] r_cnt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         r_cnt <= '0;
      else if (i_clr || o_tick)
         r_cnt <= '0;
      else
         r_cnt <= r_cnt + W'(1);
   end

   assign o_tick     = (r_cnt == W'(CLKS_PER_BIT - 1));
   // One cycle early, so registered outputs can land on the final cycle of a bit.
   assign o_pre_tick = (r_cnt == W'(CLKS_PER_BIT - 2));

endmodule

// File: rtl/uart_tx.sv
// 8-bit serial transmitter (idle-high, LSB first, optional even parity, 1/2 stop bits)
// with a one-byte holding register so the next byte is taken while a frame shifts out.
module uart_tx
   import uart_tx_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter bit          PARITY_EN    = 1'b0,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic      i_clk,
   input  logic      i_rst,
   uart_tx_if.slave  bus
);

   tx_state_e            r_state;
   logic [DATA_BITS-1:0] r_hold;
   logic                 r_hold_full;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_par;
   logic [2:0]           r_bit_idx;
   logic                 r_tx;
   logic                 r_ready;
   logic                 r_busy;
   logic                 r_done;

   logic w_tick;
   logic w_pre_tick;
   logic w_clr;
   logic w_accept;
   logic w_last_stop;
   logic w_load;

   uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_clr      (w_clr),
      .o_tick     (w_tick),
      .o_pre_tick (w_pre_tick)
   );

   assign w_clr       = (r_state == ST_IDLE);
   assign w_accept    = bus.tx_valid && r_ready;
   assign w_last_stop = (r_bit_idx == 3'(STOP_BITS - 1));
   // Drain the hold from IDLE, or straight out of the final stop bit for gapless frames.
   assign w_load      = r_hold_full &&
                        ((r_state == ST_IDLE) ||
                         ((r_state == ST_STOP) && w_tick && w_last_stop));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= ST_IDLE;
         r_hold      <= '0;
         r_hold_full <= 1'b0;
         r_shift     <= '0;
         r_par       <= 1'b0;
         r_bit_idx   <= '0;
         r_tx        <= 1'b1;
         r_ready     <= 1'b1;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_load) begin
            r_shift     <= r_hold;
            r_par       <= even_parity(r_hold);
            r_hold_full <= 1'b0;
            r_ready     <= 1'b1;
            r_bit_idx   <= '0;
            r_state     <= ST_START;
            r_tx        <= 1'b0;
            r_busy      <= 1'b1;
         end else begin
            unique case (r_state)
               ST_IDLE: ;
               ST_START:
                  if (w_tick) begin
                     r_state   <= ST_DATA;
                     r_bit_idx <= '0;
                     r_tx      <= r_shift[0];
                  end
               ST_DATA:
                  if (w_tick) begin
                     if (r_bit_idx == 3'(DATA_BITS - 1)) begin
                        r_bit_idx <= '0;
                        if (PARITY_EN) begin
                           r_state <= ST_PARITY;
                           r_tx    <= r_par;
                        end else begin
                           r_state <= ST_STOP;
                           r_tx    <= 1'b1;
                        end
                     end else begin
                        r_shift   <= r_shift >> 1;
                        r_tx      <= r_shift[1];
                        r_bit_idx <= r_bit_idx + 3'd1;
                     end
                  end
               ST_PARITY:
                  if (w_tick) begin
                     r_state   <= ST_STOP;
                     r_bit_idx <= '0;
                     r_tx      <= 1'b1;
                  end
               ST_STOP: begin
                  if (w_pre_tick && w_last_stop)
                     r_done <= 1'b1;
                  if (w_tick) begin
                     if (w_last_stop) begin
                        r_state   <= ST_IDLE;
                        r_bit_idx <= '0;
                        r_busy    <= 1'b0;
                     end else begin
                        r_bit_idx <= r_bit_idx + 3'd1;
                     end
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
         if (w_accept) begin
            r_hold      <= bus.tx_data;
            r_hold_full <= 1'b1;
            r_ready     <= 1'b0;
         end
      end
   end

   assign bus.tx_ready = r_ready;
   assign bus.tx       = r_tx;
   assign bus.tx_busy  = r_busy;
   assign bus.tx_done  = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx: 8N1 instance and a parity/2-stop instance.
module tb_uart_tx;

   localparam int CPB = 8;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;
   int   w;

   uart_tx_if b1 ();
   uart_tx_if b2 ();

   uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0), .STOP_BITS(1)) dut1 (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (b1)
   );

   uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .STOP_BITS(2)) dut2 (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (b2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic tx_of(input bit sel);
      return sel ? b2.tx : b1.tx;
   endfunction
   function automatic logic ready_of(input bit sel);
      return sel ? b2.tx_ready : b1.tx_ready;
   endfunction
   function automatic logic busy_of(input bit sel);
      return sel ? b2.tx_busy : b1.tx_busy;
   endfunction
   function automatic logic done_of(input bit sel);
      return sel ? b2.tx_done : b1.tx_done;
   endfunction

   task automatic drive(input bit sel, input logic v, input logic [7:0] d);
      if (sel) begin
         b2.tx_valid = v;
         b2.tx_data  = d;
      end else begin
         b1.tx_valid = v;
         b1.tx_data  = d;
      end
   endtask

   // Present a byte and hold it until accepted; returns the number of cycles spent waiting.
   task automatic offer(input string tag, input bit sel, input logic [7:0] d,
                        input int budget, output int waited);
      waited = 0;
      drive(sel, 1'b1, d);
      while (ready_of(sel) !== 1'b1 && waited < budget) begin
         tick();
         waited++;
      end
      if (ready_of(sel) !== 1'b1)
         check({tag, "_accept_timeout"}, ready_of(sel), 1);
      tick();
      drive(sel, 1'b0, d);
   endtask

   task automatic wait_start(input string tag, input bit sel);
      int n = 0;
      while (tx_of(sel) !== 1'b0 && n < 20) begin
         tick();
         n++;
      end
      check({tag, "_start_seen"}, tx_of(sel), 0);
   endtask

   // Called on the first start-bit cycle; returns on the last stop-bit cycle.
   task automatic check_frame(input string tag, input bit sel, input logic [7:0] b,
                              input int par_en, input int nstop);
      logic [11:0] seq;
      logic [7:0]  s;
      int          nbits;
      int          done_cnt;
      int          done_at;
      nbits = 10 + par_en + nstop - 1;
      seq = '1;
      seq[0] = 1'b0;
      for (int i = 0; i < 8; i++) seq[i+1] = b[i];
      if (par_en != 0) seq[9] = ^b;
      done_cnt = 0;
      done_at  = 0;
      check({tag, "_busy"}, busy_of(sel), 1);
      for (int k = 0; k < nbits; k++) begin
         for (int c = 0; c < CPB; c++) begin
            s[c] = tx_of(sel);
            if (done_of(sel) === 1'b1) begin
               done_cnt++;
               done_at = k * CPB + c + 1;
            end
            if (!(k == nbits - 1 && c == CPB - 1)) tick();
         end
         check($sformatf("%s_bit%0d", tag, k), s, {8{seq[k]}});
      end
      check({tag, "_done_cnt"}, done_cnt, 1);
      check({tag, "_done_at"}, done_at, nbits * CPB);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst   = 1'b0;
      drive(0, 1'b0, 8'h00);
      drive(1, 1'b0, 8'h00);

      // 1: asynchronous reset between clock edges
      #12 rst = 1'b1;
      #1;
      check("t1_tx", b1.tx, 1);
      check("t1_ready", b1.tx_ready, 1);
      check("t1_busy", b1.tx_busy, 0);
      check("t1_done", b1.tx_done, 0);
      check("t1_tx_p", b2.tx, 1);
      tick();
      tick();
      rst = 1'b0;
      tick();
      tick();
      check("t1_idle_tx", b1.tx, 1);
      check("t1_idle_ready", b1.tx_ready, 1);

      // 2: single byte 0xA5, two-clock latency to start bit
      offer("t2", 0, 8'hA5, 20, w);
      check("t2_wait", w, 0);
      check("t2_ready_low", b1.tx_ready, 0);
      check("t2_tx_before", b1.tx, 1);
      tick();
      check("t2_latency", b1.tx, 0);
      check_frame("t2", 0, 8'hA5, 0, 1);
      tick();
      check("t2_after_tx", b1.tx, 1);
      check("t2_after_busy", b1.tx_busy, 0);
      check("t2_after_ready", b1.tx_ready, 1);
      repeat (3) tick();

      // 3/4: back-to-back frames, third byte stalls until the hold drains
      offer("t3a", 0, 8'h00, 20, w);
      wait_start("t3", 0);
      fork
         begin
            check_frame("t3_f1", 0, 8'h00, 0, 1);
            tick();
            check_frame("t3_f2", 0, 8'hFF, 0, 1);
            tick();
            check_frame("t3_f3", 0, 8'h5A, 0, 1);
            tick();
            check("t3_end_busy", b1.tx_busy, 0);
            check("t3_end_tx", b1.tx, 1);
         end
         begin
            offer("t3b", 0, 8'hFF, 20, w);
            check("t3_ff_wait", w, 0);
            check("t3_ready_low", b1.tx_ready, 0);
            offer("t4", 0, 8'h5A, 200, w);
            check("t4_third_wait", w, 79);
         end
      join
      repeat (3) tick();

      // 5: even parity with two stop bits
      offer("t5", 1, 8'h07, 20, w);
      wait_start("t5", 1);
      check_frame("t5", 1, 8'h07, 1, 2);
      tick();
      check("t5_after_busy", b2.tx_busy, 0);
      repeat (3) tick();

      // 6: reset during data bit 4 with a second byte held
      offer("t6a", 0, 8'h3C, 20, w);
      wait_start("t6", 0);
      offer("t6b", 0, 8'h11, 20, w);
      check("t6_ready_low", b1.tx_ready, 0);
      repeat (42) tick();
      check("t6_d4", b1.tx, 1);
      check("t6_busy_pre", b1.tx_busy, 1);
      #3 rst = 1'b1;
      #1;
      check("t6_rst_tx", b1.tx, 1);
      check("t6_rst_ready", b1.tx_ready, 1);
      check("t6_rst_busy", b1.tx_busy, 0);
      tick();
      rst = 1'b0;
      begin
         int lows  = 0;
         int busys = 0;
         for (int i = 0; i < 40; i++) begin
            tick();
            if (b1.tx !== 1'b1) lows++;
            if (b1.tx_busy !== 1'b0) busys++;
         end
         check("t6_no_frame_tx", lows, 0);
         check("t6_no_frame_busy", busys, 0);
      end
      check("t6_ready_after", b1.tx_ready, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
